fifo_rd_stream_adapter: RTL



---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_rd_stream_adapter.sv | 68 ++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   BUF_DEPTH : output buffer entries (fixed at 2: one held word plus one
//               read in flight is the minimum for one word per cycle).
//   buf_cnt_t : occupancy count of the output buffer (0..2).
package fifo_pkg;
  localparam int BUF_DEPTH = 2;
  typedef logic [1:0] buf_cnt_t;
endpackage

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
// Turns the one-cycle-latency read port of a synchronous FIFO into a
// valid/ready stream through a 2-entry output buffer.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   fifo_empty        : FIFO empty flag
//   rd_data           : FIFO read data, valid the cycle after an accepted pop
//   pop               : FIFO read request
//   m_valid/m_ready   : stream handshake
//   m_data            : stream word, always the registered buffer head
//   idle              : nothing buffered, nothing in flight, FIFO empty
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pop,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  idle
);

  buf_cnt_t                               cnt;
  logic                                   inflight;
  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0]   slot_q;

  logic       deq;
  logic [2:0] occ;     // words owned after this cycle: buffered + arriving - leaving
  logic       wr_idx;  // slot that an arriving word lands in

  assign m_valid = (cnt != 2'd0);
  assign m_data  = slot_q[0];
  assign deq     = m_valid & m_ready;
  assign occ     = {1'b0, cnt} + {2'b00, inflight} - {2'b00, deq};

  // m_ready reaches pop combinationally so a draining buffer can refill
  // in the same cycle and sustain one word per cycle.
  assign pop     = ~reset & ~fifo_empty & (occ < 3'(BUF_DEPTH));

  // Arriving word goes right behind whatever survives this cycle's dequeue.
  assign wr_idx  = ((cnt - {1'b0, deq}) == 2'd1);

  assign idle    = (cnt == 2'd0) & ~inflight & fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      inflight <= 1'b0;
      slot_q   <= '0;
    end else begin
      inflight <= pop;
      cnt      <= occ[1:0];
      if (deq) slot_q[0] <= slot_q[1];
      // Capture after the shift so a word landing in slot 0 wins over it.
      if (inflight) slot_q[wr_idx] <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (occ <= 3'(BUF_DEPTH));
  end

endmodule
